// File: rtl/sgpr_pkg.sv
// Shared types and helpers for the SGPR write path: request layout, widths and
// the write/read overlap test used by the RAW-hazard query.
package sgpr_pkg;

    localparam int NUM_WAVES   = 16;
    localparam int WAVE_ID_W   = $clog2(NUM_WAVES);
    localparam int SGPR_ADDR_W = 7;

    typedef struct packed {
        logic [WAVE_ID_W-1:0]   wave_id;
        logic [SGPR_ADDR_W-1:0] addr;
        logic [63:0]            data;
        logic [1:0]             dword_en;
    } sgpr_req_t;

    localparam int SGPR_REQ_SIZE = $bits(sgpr_req_t);

    // Dword 1 lands at addr+1; the top-index wrap is never issued by software.
    function automatic logic sgpr_req_covers(input sgpr_req_t req,
                                             input logic [WAVE_ID_W-1:0] wave,
                                             input logic [SGPR_ADDR_W-1:0] addr);
        logic [SGPR_ADDR_W-1:0] hi_addr;
        hi_addr = req.addr + SGPR_ADDR_W'(1'b1);
        return (req.wave_id == wave) &&
               ((req.dword_en[0] && (req.addr == addr)) ||
                (req.dword_en[1] && (hi_addr == addr)));
    endfunction

endpackage

// File: rtl/decoupled_intr.sv
// Generic valid/ready handshake carrying a flat payload of W bits.
interface decoupled_intr #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sgpr_wr_fifo.sv
// Synchronous circular-buffer FIFO with extra pointer MSB for full/empty, and a
// flat view of every slot plus its occupancy bit for associative lookups.
module sgpr_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH*W-1:0]       entries,
    output logic [DEPTH-1:0]         valids
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         do_push_s;
    logic         do_pop_s;

    assign count     = wr_ptr_r - rd_ptr_r;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
        end
    end

    // Slot storage; stale slots are masked by valids so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign entries[g*W +: W] = mem_r[g];
    end

    // A slot is live when its distance from the read pointer is below occupancy.
    always_comb begin
        logic [AW-1:0] off_s;
        off_s  = '0;
        valids = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off_s     = AW'(i) - rd_ptr_r[AW-1:0];
            valids[i] = ({1'b0, off_s} < count);
        end
    end

endmodule

// File: rtl/sgpr_wr_ctrl.sv
// SGPR write controller: buffers SALU write requests, drains them in order
// through a registered bank port, and answers RAW-hazard queries.
module sgpr_wr_ctrl
    import sgpr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoupled_intr.slave             sgpr_wr_req,
    output logic                     bank_wr_valid,
    input  logic                     bank_wr_ready,
    output logic [WAVE_ID_W-1:0]     bank_wr_wave,
    output logic [SGPR_ADDR_W-1:0]   bank_wr_addr,
    output logic [63:0]              bank_wr_data,
    output logic [1:0]               bank_wr_dword_en,
    input  logic [WAVE_ID_W-1:0]     hz_query_wave,
    input  logic [SGPR_ADDR_W-1:0]   hz_query_addr,
    output logic                     hz_busy,
    output logic [$clog2(DEPTH)+1:0] pending_cnt,
    output logic                     idle
);
    localparam int CW = $clog2(DEPTH) + 2;

    sgpr_req_t                   in_req_s;
    sgpr_req_t                   head_s;
    sgpr_req_t                   out_req_r;
    logic                        out_vld_r;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic                        fifo_push_s;
    logic                        load_s;
    logic [$clog2(DEPTH):0]      fifo_count_s;
    logic [DEPTH*SGPR_REQ_SIZE-1:0] fifo_entries_s;
    logic [DEPTH-1:0]            fifo_valids_s;
    logic                        hz_s;

    assign in_req_s          = sgpr_req_t'(sgpr_wr_req.data);
    assign sgpr_wr_req.ready = !fifo_full_s;
    // Empty-enable requests are acknowledged but never enter the queue.
    assign fifo_push_s       = sgpr_wr_req.valid && !fifo_full_s && (|in_req_s.dword_en);
    assign load_s            = !fifo_empty_s && (!out_vld_r || bank_wr_ready);

    sgpr_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (SGPR_REQ_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push_s),
        .push_data (in_req_s),
        .pop       (load_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .entries   (fifo_entries_s),
        .valids    (fifo_valids_s)
    );

    // Output register: refill from the head, clear when drained, hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_r <= 1'b0;
            out_req_r <= '0;
        end else if (load_s) begin
            out_vld_r <= 1'b1;
            out_req_r <= head_s;
        end else if (bank_wr_ready) begin
            out_vld_r <= 1'b0;
        end
    end

    assign bank_wr_valid    = out_vld_r;
    assign bank_wr_wave     = out_req_r.wave_id;
    assign bank_wr_addr     = out_req_r.addr;
    assign bank_wr_data     = out_req_r.data;
    assign bank_wr_dword_en = out_req_r.dword_en;

    // Hazard OR-tree across live FIFO slots and the output register.
    always_comb begin
        hz_s = out_vld_r && sgpr_req_covers(out_req_r, hz_query_wave, hz_query_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valids_s[i] &&
                sgpr_req_covers(sgpr_req_t'(fifo_entries_s[i*SGPR_REQ_SIZE +: SGPR_REQ_SIZE]),
                                hz_query_wave, hz_query_addr)) begin
                hz_s = 1'b1;
            end else begin
                hz_s = hz_s;
            end
        end
    end

    assign hz_busy     = hz_s;
    assign pending_cnt = {1'b0, fifo_count_s} + CW'(out_vld_r);
    assign idle        = (pending_cnt == CW'(1'b0));

endmodule

// File: tb/tb_sgpr_wr_ctrl.sv
// Directed self-checking bench for sgpr_wr_ctrl with hand-computed expectations.
module tb_sgpr_wr_ctrl;
    import sgpr_pkg::*;

    localparam int DEPTH = 4;

    logic                     clk;
    logic                     rst_n;
    logic                     bank_wr_valid;
    logic                     bank_wr_ready;
    logic [WAVE_ID_W-1:0]     bank_wr_wave;
    logic [SGPR_ADDR_W-1:0]   bank_wr_addr;
    logic [63:0]              bank_wr_data;
    logic [1:0]               bank_wr_dword_en;
    logic [WAVE_ID_W-1:0]     hz_query_wave;
    logic [SGPR_ADDR_W-1:0]   hz_query_addr;
    logic                     hz_busy;
    logic [$clog2(DEPTH)+1:0] pending_cnt;
    logic                     idle;

    int n_cmp = 0;
    int n_err = 0;

    decoupled_intr #(.W(SGPR_REQ_SIZE)) req_if ();

    sgpr_wr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sgpr_wr_req      (req_if),
        .bank_wr_valid    (bank_wr_valid),
        .bank_wr_ready    (bank_wr_ready),
        .bank_wr_wave     (bank_wr_wave),
        .bank_wr_addr     (bank_wr_addr),
        .bank_wr_data     (bank_wr_data),
        .bank_wr_dword_en (bank_wr_dword_en),
        .hz_query_wave    (hz_query_wave),
        .hz_query_addr    (hz_query_addr),
        .hz_busy          (hz_busy),
        .pending_cnt      (pending_cnt),
        .idle             (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int wave, input int addr, input logic [63:0] data, input logic [1:0] en);
        sgpr_req_t r;
        r.wave_id  = WAVE_ID_W'(wave);
        r.addr     = SGPR_ADDR_W'(addr);
        r.data     = data;
        r.dword_en = en;
        req_if.valid = 1'b1;
        req_if.data  = r;
    endtask

    task automatic query(input int wave, input int addr);
        hz_query_wave = WAVE_ID_W'(wave);
        hz_query_addr = SGPR_ADDR_W'(addr);
        #1;
    endtask

    initial begin
        sgpr_req_t exp_q[$];
        sgpr_req_t e;
        sgpr_req_t held;
        sgpr_req_t obs;
        logic      stalled;
        int        pushed;
        int        written;

        rst_n         = 1'b0;
        bank_wr_ready = 1'b0;
        req_if.valid  = 1'b0;
        req_if.data   = '0;
        hz_query_wave = '0;
        hz_query_addr = '0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_eq("rst_valid", bank_wr_valid, 0);
        check_eq("rst_data",  bank_wr_data, 0);
        check_eq("rst_cnt",   pending_cnt, 0);
        check_eq("rst_idle",  idle, 1);
        check_eq("rst_ready", req_if.ready, 1);
        check_eq("rst_hz",    hz_busy, 0);

        // Single write, bank always ready: strobe two edges after accept.
        bank_wr_ready = 1'b1;
        query(3, 10);
        drive_req(3, 10, 64'h0000_0000_DEAD_BEEF, 2'b01);
        step();
        req_if.valid = 1'b0;
        check_eq("s1_cnt",   pending_cnt, 1);
        check_eq("s1_hz",    hz_busy, 1);
        check_eq("s1_valid", bank_wr_valid, 0);
        step();
        check_eq("s2_valid", bank_wr_valid, 1);
        check_eq("s2_data",  bank_wr_data, 64'h0000_0000_DEAD_BEEF);
        check_eq("s2_wave",  bank_wr_wave, 3);
        check_eq("s2_addr",  bank_wr_addr, 10);
        check_eq("s2_en",    bank_wr_dword_en, 2'b01);
        check_eq("s2_hz",    hz_busy, 1);
        check_eq("s2_cnt",   pending_cnt, 1);
        step();
        check_eq("s3_valid", bank_wr_valid, 0);
        check_eq("s3_hz",    hz_busy, 0);
        check_eq("s3_cnt",   pending_cnt, 0);
        check_eq("s3_idle",  idle, 1);

        // Pair write held in the output register: covers addr and addr+1 only.
        bank_wr_ready = 1'b0;
        drive_req(0, 20, 64'h1111_2222_3333_4444, 2'b11);
        step();
        req_if.valid = 1'b0;
        query(0, 20); check_eq("pair_fifo_0_20", hz_busy, 1);
        query(0, 21); check_eq("pair_fifo_0_21", hz_busy, 1);
        step();
        query(0, 20); check_eq("pair_0_20", hz_busy, 1);
        query(0, 21); check_eq("pair_0_21", hz_busy, 1);
        query(0, 22); check_eq("pair_0_22", hz_busy, 0);
        query(1, 20); check_eq("pair_1_20", hz_busy, 0);
        query(0, 19); check_eq("pair_0_19", hz_busy, 0);
        bank_wr_ready = 1'b1;
        step();
        check_eq("pair_drained", idle, 1);

        // Fill: 1 in output register + DEPTH in FIFO while the bank stalls.
        bank_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("fill_ready", req_if.ready, 1);
            drive_req(i + 1, 30 + i, 64'(100 + i), 2'b01);
            step();
        end
        req_if.valid = 1'b0;
        check_eq("fill_cnt",   pending_cnt, 5);
        check_eq("fill_full",  req_if.ready, 0);
        check_eq("fill_idle",  idle, 0);
        query(5, 34); check_eq("fill_hz_tail", hz_busy, 1);
        bank_wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("drain_valid", bank_wr_valid, 1);
            check_eq("drain_addr",  bank_wr_addr, 30 + i);
            check_eq("drain_data",  bank_wr_data, 100 + i);
            step();
        end
        check_eq("drain_done", bank_wr_valid, 0);
        check_eq("drain_cnt",  pending_cnt, 0);

        // Empty-enable request is acknowledged and dropped.
        check_eq("z_ready", req_if.ready, 1);
        drive_req(2, 5, 64'hFFFF, 2'b00);
        step();
        req_if.valid = 1'b0;
        check_eq("z_cnt1",  pending_cnt, 0);
        check_eq("z_idle1", idle, 1);
        step();
        check_eq("z_valid", bank_wr_valid, 0);
        check_eq("z_idle2", idle, 1);

        // 16-write stream against a bank toggling ready every cycle.
        pushed  = 0;
        written = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 300 && written < 16; cyc++) begin
            bank_wr_ready = cyc[0];
            if (pushed < 16 && req_if.ready) begin
                e.wave_id  = WAVE_ID_W'(pushed);
                e.addr     = SGPR_ADDR_W'(40 + pushed);
                e.data     = {32'(pushed), 32'hC0DE_0000 + 32'(pushed)};
                e.dword_en = 2'((pushed % 3) + 1);
                req_if.valid = 1'b1;
                req_if.data  = e;
                exp_q.push_back(e);
                pushed++;
            end else begin
                req_if.valid = 1'b0;
            end
            #1;
            obs = {bank_wr_wave, bank_wr_addr, bank_wr_data, bank_wr_dword_en};
            if (stalled) check_eq("strm_stable", obs, held);
            if (bank_wr_valid && bank_wr_ready) begin
                if (exp_q.size() > 0) check_eq("strm_order", obs, exp_q.pop_front());
                else check_eq("strm_extra", 1, 0);
                written++;
            end
            stalled = bank_wr_valid && !bank_wr_ready;
            held    = obs;
            step();
        end
        req_if.valid = 1'b0;
        check_eq("strm_written", written, 16);
        check_eq("strm_pushed",  pushed, 16);

        // Reset with writes pending and the bank stalled.
        bank_wr_ready = 1'b1;
        step();
        step();
        bank_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(7, 60 + i, 64'(i), 2'b01);
            step();
        end
        req_if.valid = 1'b0;
        check_eq("prerst_cnt", pending_cnt, 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check_eq("mrst_valid", bank_wr_valid, 0);
        check_eq("mrst_cnt",   pending_cnt, 0);
        check_eq("mrst_ready", req_if.ready, 1);
        query(7, 60); check_eq("mrst_hz", hz_busy, 0);
        bank_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("mrst_stale", bank_wr_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
